// File: rtl/bus_arbiter_rr_if.sv
// Shared 4-master bus arbitration signals.
// Master side drives the request lines and observes the grants.
// Slave side is the arbiter, which owns the grant, owner ID and status outputs.
interface bus_arbiter_rr_if;
  logic [3:0] BR;       // bus requests, bit i = master i
  logic [3:0] BG;       // one-hot bus grant, zero when the bus is free
  logic [1:0] GNT_ID;   // index of the current or last owner
  logic       BUSY;     // mirrors |BG
  logic       TIMEOUT;  // single-cycle pulse after a preemption

  modport master (
    output BR,
    input  BG,
    input  GNT_ID,
    input  BUSY,
    input  TIMEOUT
  );

  modport slave (
    input  BR,
    output BG,
    output GNT_ID,
    output BUSY,
    output TIMEOUT
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Registered round-robin arbiter for the shared 4-master bus.
// A grant is sticky: the owner keeps the bus until it drops its request.
// If other masters are waiting, the owner loses the bus once it has held it
// for MAX_HOLD cycles. Every grant is followed by TURNAROUND dead cycles.
// The search pointer moves past the last owner, so service rotates fairly.
module bus_arbiter_rr #(
  parameter int unsigned MAX_HOLD   = 16,  // grant cycles before preemption (>=1)
  parameter int unsigned TURNAROUND = 1,   // dead cycles after each grant (>=1)
  parameter int unsigned CNT_W      = 5    // hold-counter width, must hold MAX_HOLD
) (
  input  logic             CLK,
  input  logic             RST,
  bus_arbiter_rr_if.slave  bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;

  localparam int unsigned RCV_W = (TURNAROUND > 1) ? $clog2(TURNAROUND + 1) : 1;

  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE  = CNT_W'(1);
  localparam logic [RCV_W-1:0] RCV_LAST  = RCV_W'(TURNAROUND);
  localparam logic [RCV_W-1:0] RCV_ONE   = RCV_W'(1);

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

  // State and registered outputs
  logic [1:0]       state_q,    state_d;
  logic [1:0]       ptr_q,      ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [RCV_W-1:0] rcv_cnt_q,  rcv_cnt_d;
  logic [3:0]       bg_q,       bg_d;
  logic [1:0]       gnt_id_q,   gnt_id_d;
  logic             busy_q,     busy_d;
  logic             timeout_q,  timeout_d;

  // Arbitration helpers
  logic       win_found;
  logic [1:0] win_idx;
  logic [3:0] owner_oh;
  logic       owner_req;
  logic       others_wait;
  logic       hold_full;

  // Rotating-priority search: first requester at or after the pointer
  always_comb begin : winner_scan
    logic [1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!win_found && bus.BR[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Owner status used by the hold/release decision
  always_comb begin
    owner_oh    = onehot4(gnt_id_q);
    owner_req   = bus.BR[gnt_id_q];
    others_wait = |(bus.BR & ~owner_oh);
    hold_full   = (hold_cnt_q == HOLD_MAX);
  end

  // Next-state logic for IDLE / GRANT / RECOVER
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    rcv_cnt_d  = rcv_cnt_q;
    bg_d       = bg_q;
    gnt_id_d   = gnt_id_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          bg_d       = onehot4(win_idx);
          gnt_id_d   = win_idx;
          busy_d     = 1'b1;
          hold_cnt_d = HOLD_ONE;
          state_d    = ST_GRANT;
        end
      end

      ST_GRANT: begin
        // A voluntary release takes precedence; TIMEOUT flags only a
        // preemption, i.e. the owner was still requesting when cut off.
        if (!owner_req || (hold_full && others_wait)) begin
          bg_d      = '0;
          busy_d    = 1'b0;
          ptr_d     = gnt_id_q + 2'd1;
          rcv_cnt_d = RCV_ONE;
          timeout_d = owner_req;
          state_d   = ST_RECOVER;
        end else if (!hold_full) begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
      end

      ST_RECOVER: begin
        // Requests are ignored here; they are sampled again once in IDLE.
        if (rcv_cnt_q == RCV_LAST) begin
          rcv_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          rcv_cnt_d = rcv_cnt_q + RCV_ONE;
        end
      end

      default: begin
        bg_d    = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; synchronous reset aborts any active grant
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      rcv_cnt_q  <= '0;
      bg_q       <= '0;
      gnt_id_q   <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      rcv_cnt_q  <= rcv_cnt_d;
      bg_q       <= bg_d;
      gnt_id_q   <= gnt_id_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.BG      = bg_q;
  assign bus.GNT_ID  = gnt_id_q;
  assign bus.BUSY    = busy_q;
  assign bus.TIMEOUT = timeout_q;

endmodule
